// File: rtl/fpr_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fpr_cdb_arbiter
//  Purpose  : Shares the single FPR common data bus among N_REQ floating-point
//             result producers (fmov, fadd, fmul, fdiv/fsqrt, fcvt). A unit is
//             granted combinationally. It loads its own result register on the
//             grant edge. The arbiter broadcasts {valid, tag, data} on the CDB
//             one cycle after the grant.
//  Ports    : clk        - clock, all state updates on posedge
//             reset      - asynchronous active-low reset
//             flush      - synchronous pipeline flush, blocks all grants
//             req_valid  - per-unit result available
//             req_tag    - per-unit ROB tag, qualified by req_valid
//             req_ready  - one-hot grant, combinational
//             req_data   - per-unit registered result, read the cycle after
//                          the grant
//             cdb_valid  - CDB broadcast valid
//             cdb_tag    - CDB broadcast tag
//             cdb_data   - CDB broadcast data
//             cdb_src    - index of the unit currently on the CDB
//  Options  : ARB_FIXED_PRIO_EN - when defined, arbitration uses fixed
//             priority (the lowest index wins) and the round-robin pointer is
//             removed.
//  Revision : 1.0 - initial release
// ============================================================================

// ROB_WIDTH normally arrives from common.vh. The fallback below keeps this
// file self-contained.
`ifndef ROB_WIDTH
`define ROB_WIDTH 6
`endif

module fpr_cdb_arbiter #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 32
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               flush,
   input  logic [N_REQ-1:0]                   req_valid,
   input  logic [N_REQ-1:0][`ROB_WIDTH-1:0]   req_tag,
   output logic [N_REQ-1:0]                   req_ready,
   input  logic [N_REQ-1:0][DATA_W-1:0]       req_data,
   output logic                               cdb_valid,
   output logic [`ROB_WIDTH-1:0]              cdb_tag,
   output logic [DATA_W-1:0]                  cdb_data,
   output logic [$clog2(N_REQ)-1:0]           cdb_src
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int ROB_W = `ROB_WIDTH;
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_REQ - 1);

   logic [IDX_W-1:0] w_start;
   logic [IDX_W-1:0] w_scan;
   logic [IDX_W-1:0] w_gnt_idx;
   logic             w_found;
   logic             w_hs;

   logic             r_pend_valid;
   logic [IDX_W-1:0] r_pend_idx;
   logic [ROB_W-1:0] r_pend_tag;

`ifdef ARB_FIXED_PRIO_EN
   // Fixed priority: the search always begins at unit 0 (fmov).
   assign w_start = '0;
`else
   logic [IDX_W-1:0] r_rr_ptr;

   assign w_start = r_rr_ptr;

   // The pointer moves just past the winner, so the winner becomes the lowest
   // priority next time. Flush and idle cycles leave it untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rr_ptr <= '0;
      end else if (w_hs) begin
         r_rr_ptr <= (w_gnt_idx == C_LAST_IDX) ? '0 : w_gnt_idx + 1'b1;
      end
   end
`endif

   // Circular search from w_start. The first valid request met wins.
   always_comb begin
      w_found   = 1'b0;
      w_gnt_idx = '0;
      w_scan    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_scan = IDX_W'((int'(w_start) + k) % N_REQ);
         if (!w_found && req_valid[w_scan]) begin
            w_found   = 1'b1;
            w_gnt_idx = w_scan;
         end
      end
   end

   // Reset is folded in so that no unit sees a grant while the machine is
   // held in reset.
   assign w_hs = w_found && reset && !flush;

   always_comb begin
      req_ready = '0;
      if (w_hs) begin
         req_ready[w_gnt_idx] = 1'b1;
      end
   end

   // The grant register captures the tag now. The data is read next cycle
   // from the unit's own result register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pend_valid <= 1'b0;
         r_pend_idx   <= '0;
         r_pend_tag   <= '0;
      end else begin
         r_pend_valid <= w_hs;
         if (w_hs) begin
            r_pend_idx <= w_gnt_idx;
            r_pend_tag <= req_tag[w_gnt_idx];
         end
      end
   end

   // Tag, source and data keep their last values when idle, so the bus is
   // never driven with X.
   assign cdb_valid = r_pend_valid;
   assign cdb_tag   = r_pend_tag;
   assign cdb_src   = r_pend_idx;
   assign cdb_data  = req_data[r_pend_idx];

endmodule

`default_nettype wire

// File: tb/tb_fpr_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpr_cdb_arbiter
//  Purpose  : Self-checking bench for fpr_cdb_arbiter. It applies a directed
//             vector table, a randomized phase checked against a
//             distance-based arbitration model, and an asynchronous
//             mid-cycle reset sequence.
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef ROB_WIDTH
`define ROB_WIDTH 6
`endif

module tb_fpr_cdb_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int TW = `ROB_WIDTH;

   logic                   clk;
   logic                   reset;
   logic                   flush;
   logic [N-1:0]           req_valid;
   logic [N-1:0][TW-1:0]   req_tag;
   logic [N-1:0]           req_ready;
   logic [N-1:0][DW-1:0]   req_data;
   logic                   cdb_valid;
   logic [TW-1:0]          cdb_tag;
   logic [DW-1:0]          cdb_data;
   logic [1:0]             cdb_src;

   fpr_cdb_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .req_valid (req_valid),
      .req_tag   (req_tag),
      .req_ready (req_ready),
      .req_data  (req_data),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .cdb_src   (cdb_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [N-1:0]          valid;
      logic                  fl;
      logic [N-1:0][TW-1:0]  tags;
      logic [N-1:0]          ready;
      logic                  cv;
      logic [TW-1:0]         ctag;
      logic [1:0]            src;
   } vec_t;

   vec_t tbl [19];

   function automatic logic [N-1:0][TW-1:0] pk(input int t3, input int t2, input int t1, input int t0);
      logic [N-1:0][TW-1:0] r;
      r[3] = TW'(t3); r[2] = TW'(t2); r[1] = TW'(t1); r[0] = TW'(t0);
      return r;
   endfunction

   function automatic vec_t mk(input logic [N-1:0] v, input logic f, input logic [N-1:0][TW-1:0] t,
                               input logic [N-1:0] rdy, input logic cv, input int ctag, input int src);
      vec_t r;
      r.valid = v; r.fl = f; r.tags = t; r.ready = rdy; r.cv = cv;
      r.ctag = TW'(ctag); r.src = 2'(src);
      return r;
   endfunction

   // Reference arbitration: among valid units, pick the one at the smallest
   // circular distance ahead of the pointer (fixed priority: smallest index).
   function automatic int winner(input logic [N-1:0] v, input int ptr);
      int best = -1;
      int bestd = N;
      for (int i = 0; i < N; i++) begin
         if (v[i]) begin
            int d;
`ifdef ARB_FIXED_PRIO_EN
            d = i;
`else
            d = (i - ptr + N) % N;
`endif
            if (d < bestd) begin
               bestd = d;
               best = i;
            end
         end
      end
      return best;
   endfunction

   logic [DW-1:0] data_c [N];

   // Model state used in the random phase.
   int            m_ptr;
   logic          m_pv;
   int            m_pidx;
   logic [TW-1:0] m_ptag;
   int            starve [N];

   initial begin
      data_c[0] = 32'h3F800000; data_c[1] = 32'h40000000;
      data_c[2] = 32'h40400000; data_c[3] = 32'h40800000;

      // ---------------- directed table ----------------
`ifdef ARB_FIXED_PRIO_EN
      for (int r = 0; r < 8; r++)
         tbl[r] = mk(4'b1111, 0, pk(13,12,11,10), 4'b0001, r != 0, (r != 0) ? 10 : 0, 0);
      tbl[8]  = mk(4'b0000, 0, pk(13,12,11,10), 4'b0000, 1, 10, 0);
`else
      for (int r = 0; r < 8; r++)
         tbl[r] = mk(4'b1111, 0, pk(13,12,11,10), 4'b0001 << (r % 4), r != 0,
                     (r != 0) ? 10 + ((r - 1) % 4) : 0, (r != 0) ? (r - 1) % 4 : 0);
      tbl[8]  = mk(4'b0000, 0, pk(13,12,11,10), 4'b0000, 1, 13, 3);
`endif
      tbl[9]  = mk(4'b0001, 0, pk(0,0,0,5), 4'b0001, 0, 0, 0);
      tbl[10] = mk(4'b0000, 0, pk(0,0,0,5), 4'b0000, 1, 5, 0);
      tbl[11] = mk(4'b0100, 0, pk(0,9,0,0), 4'b0100, 0, 0, 0);
      tbl[12] = mk(4'b0011, 1, pk(0,0,8,7), 4'b0000, 1, 9, 2);
      tbl[13] = mk(4'b0011, 0, pk(0,0,8,7), 4'b0001, 0, 0, 0);
      tbl[14] = mk(4'b0100, 0, pk(0,1,0,0), 4'b0100, 1, 7, 0);
      tbl[15] = mk(4'b0100, 0, pk(0,2,0,0), 4'b0100, 1, 1, 2);
      tbl[16] = mk(4'b0100, 0, pk(0,3,0,0), 4'b0100, 1, 2, 2);
      tbl[17] = mk(4'b0000, 0, pk(0,0,0,0), 4'b0000, 1, 3, 2);
      tbl[18] = mk(4'b0000, 0, pk(0,0,0,0), 4'b0000, 0, 0, 0);

      // ---------------- reset state ----------------
      reset = 1'b0; flush = 1'b0; req_valid = 4'b0001; req_tag = pk(0,0,0,5);
      for (int i = 0; i < N; i++) req_data[i] = data_c[i];
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
      chk("rst_cdb_tag", 64'(cdb_tag), 64'h0);
      chk("rst_cdb_src", 64'(cdb_src), 64'h0);
      @(posedge clk); #1;
      reset = 1'b1;

      for (int r = 0; r < 19; r++) begin
         req_valid = tbl[r].valid; flush = tbl[r].fl; req_tag = tbl[r].tags;
         @(negedge clk);
         chk($sformatf("tbl%0d_ready", r), 64'(req_ready), 64'(tbl[r].ready));
         chk($sformatf("tbl%0d_cdb_valid", r), 64'(cdb_valid), 64'(tbl[r].cv));
         if (tbl[r].cv) begin
            chk($sformatf("tbl%0d_cdb_tag", r), 64'(cdb_tag), 64'(tbl[r].ctag));
            chk($sformatf("tbl%0d_cdb_src", r), 64'(cdb_src), 64'(tbl[r].src));
            chk($sformatf("tbl%0d_cdb_data", r), 64'(cdb_data), 64'(data_c[tbl[r].src]));
         end
         @(posedge clk); #1;
      end

      // ---------------- randomized phase ----------------
      m_ptr = 3; m_pv = 1'b0; m_pidx = 0; m_ptag = '0;
      for (int i = 0; i < N; i++) starve[i] = 0;
      for (int c = 0; c < 400; c++) begin
         int w;
         logic hs;
         logic [N-1:0] exp_rdy;
         req_valid = 4'($urandom_range(0, 15));
         flush = ($urandom_range(0, 9) == 0);
         for (int i = 0; i < N; i++) begin
            req_tag[i]  = TW'($urandom);
            req_data[i] = DW'($urandom);
         end
         w = winner(req_valid, m_ptr);
         hs = (w >= 0) && !flush;
         exp_rdy = hs ? (4'b0001 << w) : 4'b0000;
         @(negedge clk);
         chk("rnd_ready", 64'(req_ready), 64'(exp_rdy));
         chk("rnd_cdb_valid", 64'(cdb_valid), 64'(m_pv));
         if (m_pv) begin
            chk("rnd_cdb_tag", 64'(cdb_tag), 64'(m_ptag));
            chk("rnd_cdb_src", 64'(cdb_src), 64'(m_pidx));
            chk("rnd_cdb_data", 64'(cdb_data), 64'(req_data[m_pidx]));
         end
`ifndef ARB_FIXED_PRIO_EN
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || req_ready[i]) starve[i] = 0;
            else if (|req_ready) begin
               starve[i]++;
               chk($sformatf("rnd_starve%0d_le_%0d", i, N - 1), 64'(starve[i] <= N - 1), 64'h1);
            end
         end
`endif
         m_pv = hs;
         if (hs) begin
            m_pidx = w;
            m_ptag = req_tag[w];
            m_ptr  = (w + 1) % N;
         end
         @(posedge clk); #1;
      end

      // ---------------- asynchronous reset mid-operation ----------------
      for (int i = 0; i < N; i++) req_data[i] = data_c[i];
      flush = 1'b0; req_valid = 4'b0010; req_tag = pk(0,0,4,0);
      @(negedge clk);
      chk("ar_grant1", 64'(req_ready), 64'h2);
      @(posedge clk); #1;
      req_valid = 4'b1111;
      chk("ar_pend_visible", 64'(cdb_valid), 64'h1);
      #2 reset = 1'b0;
      #1;
      chk("ar_cdb_valid_drop", 64'(cdb_valid), 64'h0);
      chk("ar_ready_zero", 64'(req_ready), 64'h0);
      @(posedge clk); #1;
      chk("ar_hold_cdb_valid", 64'(cdb_valid), 64'h0);
      reset = 1'b1;
      #1;
      chk("ar_ptr_zero", 64'(req_ready), 64'h1);
      chk("ar_no_stale", 64'(cdb_valid), 64'h0);
      @(posedge clk); #1;
      req_valid = 4'b0000;
      @(negedge clk);
      chk("ar_post_valid", 64'(cdb_valid), 64'h1);
      chk("ar_post_src", 64'(cdb_src), 64'h0);
      chk("ar_post_data", 64'(cdb_data), 64'(data_c[0]));
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
